// File: rtl/fcl_seq_pkg.sv
// Shared types and width helpers for the binary fully-connected sequencer.
// Build option: FCL_SEQ_DOUBLE_BUF_EN (consumed by fcl_seq_resbuf) selects a
// two-entry result FIFO instead of a single result register.
package fcl_seq_pkg;

  // Sequencer states: accept a vector, issue reads, let the last product land,
  // capture the array outputs, then hand the group to the consumer.
  typedef enum logic [2:0] {
    S_IDLE,
    S_RUN,
    S_DRAIN,
    S_CAPTURE,
    S_OUT
  } seq_state_t;

  // Width of an index over n items, never narrower than one bit.
  function automatic int clog2Min1(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

  // Default configuration, matching the `BIN_PARALLEL / `ACC_WIDTH defines of the array.
  localparam int DEF_BIN_PARALLEL = 8;
  localparam int DEF_ACC_WIDTH    = 16;
  localparam int DEF_IN_LEN       = 64;
  localparam int DEF_OUT_GROUPS   = 4;

  localparam int K_W    = $clog2(DEF_IN_LEN);
  localparam int ADDR_W = $clog2(DEF_OUT_GROUPS * DEF_IN_LEN);
  localparam int GRP_W  = clog2Min1(DEF_OUT_GROUPS);

  // One returned result group in the default configuration; the top builds the
  // same layout at its own parameter widths and hands it to the result buffer.
  typedef struct packed {
    logic [DEF_BIN_PARALLEL-1:0] data;
    logic [GRP_W-1:0]            group;
    logic                        last;
  } res_t;

endpackage

// File: rtl/fcl_bin_seq_if.sv
// Bus bundle between the sequencer and its environment: activation intake,
// weight memory, PE array drive/return and the result stream.
// The master side is the sequencer, the slave side is everything around it.
interface fcl_bin_seq_if #(
  parameter int BIN_PARALLEL = 8,
  parameter int ACC_WIDTH    = 16,
  parameter int IN_LEN       = 64,
  parameter int OUT_GROUPS   = 4
);
  import fcl_seq_pkg::*;

  localparam int SH_W   = $clog2(ACC_WIDTH);
  localparam int ADDR_W = $clog2(OUT_GROUPS * IN_LEN);
  localparam int GRP_W  = clog2Min1(OUT_GROUPS);

  logic                    act_valid;
  logic                    act_ready;
  logic [IN_LEN-1:0]       act_data;
  logic [SH_W-1:0]         shift_cfg;

  logic                    w_rd;
  logic [ADDR_W-1:0]       w_addr;
  logic [BIN_PARALLEL-1:0] w_data;

  logic                    pe_in;
  logic [BIN_PARALLEL-1:0] pe_w;
  logic                    pe_run;
  logic [SH_W-1:0]         pe_shift;
  logic [BIN_PARALLEL-1:0] pe_out;

  logic                    res_valid;
  logic                    res_ready;
  logic [BIN_PARALLEL-1:0] res_data;
  logic [GRP_W-1:0]        res_group;
  logic                    res_last;

  modport master (
    input  act_valid, act_data, shift_cfg, w_data, pe_out, res_ready,
    output act_ready, w_rd, w_addr, pe_in, pe_w, pe_run, pe_shift,
           res_valid, res_data, res_group, res_last
  );

  modport slave (
    output act_valid, act_data, shift_cfg, w_data, pe_out, res_ready,
    input  act_ready, w_rd, w_addr, pe_in, pe_w, pe_run, pe_shift,
           res_valid, res_data, res_group, res_last
  );

endinterface

// File: rtl/fcl_seq_resbuf.sv
// Result buffer with a valid/ready output.
// Default: one result register. With FCL_SEQ_DOUBLE_BUF_EN defined: a
// two-entry FIFO so the sequencer can start the next group while the consumer
// still holds the previous one. o_roomAfterPush tells the sequencer whether,
// after pushing in this cycle, another group could still be stored.
module fcl_seq_resbuf #(
  parameter type res_t = fcl_seq_pkg::res_t
) (
  input  logic clk,
  input  logic rst,
  input  logic i_push,
  input  res_t i_data,
  output logic o_valid,
  input  logic i_ready,
  output res_t o_head,
  output logic o_roomAfterPush
);

`ifdef FCL_SEQ_DOUBLE_BUF_EN

  res_t       r_ent0;
  res_t       r_ent1;
  logic [1:0] r_count;
  logic       w_pop;

  assign w_pop           = (r_count != 2'd0) && i_ready;
  assign o_valid         = (r_count != 2'd0);
  assign o_head          = r_ent0;
  assign o_roomAfterPush = (r_count == 2'd0) || ((r_count == 2'd1) && w_pop);

  // Two-entry FIFO: entry 0 is always the head, entry 1 queues behind it.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_ent0  <= '0;
      r_ent1  <= '0;
      r_count <= 2'd0;
    end else begin
      case ({i_push, w_pop})
        2'b10: begin
          if (r_count == 2'd0) r_ent0 <= i_data;
          else                 r_ent1 <= i_data;
          r_count <= r_count + 2'd1;
        end
        2'b01: begin
          r_ent0  <= r_ent1;
          r_count <= r_count - 2'd1;
        end
        2'b11: begin
          if (r_count == 2'd1) begin
            r_ent0 <= i_data;
          end else begin
            r_ent0 <= r_ent1;
            r_ent1 <= i_data;
          end
        end
        default: ;
      endcase
    end
  end

`else

  res_t r_ent0;
  logic r_full;
  logic w_pop;

  assign w_pop           = r_full && i_ready;
  assign o_valid         = r_full;
  assign o_head          = r_ent0;
  assign o_roomAfterPush = 1'b0;

  // Single result register; contents stay put after a pop until the next push.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_ent0 <= '0;
      r_full <= 1'b0;
    end else if (i_push) begin
      r_ent0 <= i_data;
      r_full <= 1'b1;
    end else if (w_pop) begin
      r_full <= 1'b0;
    end
  end

`endif

endmodule

// File: rtl/fcl_bin_seq.sv
// Initiator-side sequencer for the binary fully-connected PE array.
// Takes one activation vector, streams it one bit per cycle together with
// BIN_PARALLEL weight bits from a synchronous weight memory, captures the
// array's outputs per group and returns them over a valid/ready port.
// Build option: FCL_SEQ_DOUBLE_BUF_EN (see fcl_seq_resbuf) lets the next group
// start straight after capture while a result is still waiting.
module fcl_bin_seq
  import fcl_seq_pkg::*;
#(
  parameter int BIN_PARALLEL = 8,
  parameter int ACC_WIDTH    = 16,
  parameter int IN_LEN       = 64,
  parameter int OUT_GROUPS   = 4
) (
  input logic          clk,
  input logic          rst,
  fcl_bin_seq_if.master bus
);

  localparam int K_W    = $clog2(IN_LEN);
  localparam int ADDR_W = $clog2(OUT_GROUPS * IN_LEN);
  localparam int GRP_W  = clog2Min1(OUT_GROUPS);
  localparam int SH_W   = $clog2(ACC_WIDTH);

  typedef struct packed {
    logic [BIN_PARALLEL-1:0] data;
    logic [GRP_W-1:0]        group;
    logic                    last;
  } res_local_t;

  seq_state_t        r_state;
  logic [IN_LEN-1:0] r_act;
  logic [SH_W-1:0]   r_shift;
  logic [K_W-1:0]    r_k;
  logic [K_W-1:0]    r_kd;
  logic [GRP_W-1:0]  r_group;
  logic              r_pvalid;

  logic       w_lastGrp;
  logic       w_push;
  logic       w_pop;
  logic       w_resValid;
  logic       w_room;
  res_local_t w_captured;
  res_local_t w_head;

  assign w_lastGrp  = (r_group == GRP_W'(OUT_GROUPS - 1));
  assign w_push     = (r_state == S_CAPTURE);
  assign w_pop      = w_resValid && bus.res_ready;
  assign w_captured = '{data: bus.pe_out, group: r_group, last: w_lastGrp};

  fcl_seq_resbuf #(
    .res_t(res_local_t)
  ) u_resbuf (
    .clk            (clk),
    .rst            (rst),
    .i_push         (w_push),
    .i_data         (w_captured),
    .o_valid        (w_resValid),
    .i_ready        (bus.res_ready),
    .o_head         (w_head),
    .o_roomAfterPush(w_room)
  );

  // Main sequencer: walks k over the vector for each group, then waits for
  // the result to drain (or for buffer room) before starting the next group.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_act   <= '0;
      r_shift <= '0;
      r_k     <= '0;
      r_group <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (bus.act_valid) begin
            r_act   <= bus.act_data;
            r_shift <= bus.shift_cfg;
            r_k     <= '0;
            r_group <= '0;
            r_state <= S_RUN;
          end
        end
        S_RUN: begin
          if (r_k == K_W'(IN_LEN - 1)) r_state <= S_DRAIN;
          else                         r_k     <= r_k + K_W'(1);
        end
        S_DRAIN: begin
          r_state <= S_CAPTURE;
        end
        S_CAPTURE: begin
          if (w_lastGrp || !w_room) begin
            r_state <= S_OUT;
          end else begin
            r_group <= r_group + GRP_W'(1);
            r_k     <= '0;
            r_state <= S_RUN;
          end
        end
        S_OUT: begin
          if (w_pop) begin
            if (w_head.last) begin
              r_state <= S_IDLE;
            end else if (!w_lastGrp) begin
              r_group <= r_group + GRP_W'(1);
              r_k     <= '0;
              r_state <= S_RUN;
            end
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // Products reach the array one cycle after their weight read is issued.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_pvalid <= 1'b0;
      r_kd     <= '0;
    end else begin
      r_pvalid <= (r_state == S_RUN);
      r_kd     <= r_k;
    end
  end

  assign bus.act_ready = (r_state == S_IDLE);
  assign bus.w_rd      = (r_state == S_RUN);
  assign bus.w_addr    = ADDR_W'(r_group) * ADDR_W'(IN_LEN) + ADDR_W'(r_k);

  assign bus.pe_in    = r_pvalid && r_act[r_kd];
  assign bus.pe_w     = r_pvalid ? bus.w_data : '0;
  assign bus.pe_run   = r_pvalid && (r_kd != '0);
  assign bus.pe_shift = r_shift;

  assign bus.res_valid = w_resValid;
  assign bus.res_data  = w_head.data;
  assign bus.res_group = w_head.group;
  assign bus.res_last  = w_head.last;

endmodule

// File: doc/fcl_bin_seq.md
Name: fcl_bin_seq

Overview:
- Sequencer that drives the binary fully-connected PE array (`fcl_bin`) from the initiator side.
- Accepts one IN_LEN-bit activation vector and streams it bit-serially, one bit per cycle, to the array. Streams BIN_PARALLEL weight bits per cycle from a synchronous weight memory.
- Controls accumulator load/accumulate and shift, captures the array's per-neuron outputs, and returns them one group (BIN_PARALLEL neurons) at a time over a valid/ready port.
- Covers OUT_GROUPS groups per activation vector.

Parameters:
- BIN_PARALLEL, 8, neurons per group (PE count), matches the `BIN_PARALLEL define.
- ACC_WIDTH, 16, PE accumulator width, matches the `ACC_WIDTH define.
- IN_LEN, 64, activation bits per dot product, >=2.
- OUT_GROUPS, 4, groups per activation vector, >=1.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous, active-high reset.
- act_valid  in  1  activation vector offered.
- act_ready  out  1  high only in IDLE.
- act_data  in  IN_LEN  activation bits; bit k is consumed k-th.
- shift_cfg  in  $clog2(ACC_WIDTH)  shift amount; sampled at job accept.
- w_rd  out  1  weight memory read enable.
- w_addr  out  $clog2(OUT_GROUPS*IN_LEN)  weight address = group*IN_LEN + k.
- w_data  in  BIN_PARALLEL  weight word; valid the cycle after w_rd.
- pe_in  out  1  activation bit to the array.
- pe_w  out  BIN_PARALLEL  weight bits to the array (equals w_data).
- pe_run  out  1  0 = PE loads first product, 1 = PE accumulates.
- pe_shift  out  $clog2(ACC_WIDTH)  registered shift_cfg.
- pe_out  in  BIN_PARALLEL  array output bits.
- res_valid  out  1  result group available.
- res_ready  in  1  consumer accepts.
- res_data  out  BIN_PARALLEL  captured pe_out.
- res_group  out  $clog2(OUT_GROUPS) (min 1)  group index of res_data.
- res_last  out  1  high with the final group of the vector.

Behaviour:
- Reset values (rst high at a clk edge, from any state, mid-job included):
  - State returns to IDLE; the job is abandoned.
  - act_ready=1 once in IDLE.
  - res_valid=0, res_data=0, res_group=0, res_last=0.
  - w_rd=0, pe_run=0, pe_in=0, pe_shift=0.
- States: IDLE, RUN, DRAIN, CAPTURE, OUT.
- IDLE:
  - act_ready=1.
  - On act_valid&act_ready: register act_data and shift_cfg, set group=0 and k=0, go to RUN.
- RUN (IN_LEN cycles):
  - w_rd=1 and w_addr=group*IN_LEN+k, with k incrementing 0..IN_LEN-1.
  - After k=IN_LEN-1, go to DRAIN.
- Product presentation:
  - Runs one cycle behind issue.
  - pe_in = act_q[k_d], where k_d is the registered k.
  - pe_w = w_data.
  - pe_run = 0 when k_d==0, else 1.
  - The array therefore receives products k=0..IN_LEN-1 on the cycles from the second RUN cycle through DRAIN.
- CAPTURE (1 cycle):
  - res_data <= pe_out, res_group <= group, res_last <= (group==OUT_GROUPS-1).
  - Go to OUT.
- OUT:
  - res_valid=1. res_data, res_group and res_last stay stable until res_valid&res_ready.
  - On handshake with res_last=1: go to IDLE.
  - On handshake with res_last=0: group+1, k=0, go to RUN.
- Outside product presentation:
  - pe_in=0, pe_w=0, pe_run=0.
  - The array state is don't-care; the next group reloads it through pe_run=0.
- Latency:
  - Accept to first res_valid = IN_LEN+3 cycles.
  - Group period with res_ready held high = IN_LEN+3 cycles.
- act_valid is ignored outside IDLE; no buffering.
- res_ready is ignored while res_valid=0.
- OUT_GROUPS==1: res_last=1 on the only group.
- No arithmetic here. Width rules:
  - w_addr is computed at full width with no wrap.
  - The maximum address is OUT_GROUPS*IN_LEN-1.

Optional Feature:
- Macro: FCL_SEQ_DOUBLE_BUF_EN.
- Defined:
  - Adds a second result register, forming a 2-entry result FIFO.
  - After CAPTURE, the next group goes straight to RUN when a free entry exists.
  - OUT is entered only when both entries are full.
  - Group period with res_ready high = IN_LEN+2 cycles.
  - Ordering is preserved.
  - res_valid stays high while either entry is occupied.
  - The job ends (IDLE) once the last group is popped.
- Undefined: single register, behaviour exactly as above.

Decomposition:
- Package fcl_seq_pkg holds:
  - the state enum type;
  - the width localparams: K_W=$clog2(IN_LEN), ADDR_W, GRP_W;
  - a result struct {data, group, last}.
- Natural sub-module: fcl_seq_resbuf, the 1/2-entry result buffer with valid/ready. Its depth is selected by FCL_SEQ_DOUBLE_BUF_EN.

Test Plan:
- Bench parameters: IN_LEN=8, BIN_PARALLEL=4, OUT_GROUPS=2; weight memory word at a = a[3:0].
- Pattern check: act_data=8'b1010_0110, shift_cfg=7 -> pe_in sequence 0,1,1,0,0,1,0,1; pe_w sequence 0..7 then 8..15; pe_run pattern 0,1,1,1,1,1,1,1 per group; pe_shift=7.
- Capture: bench drives pe_out=4'hA during group-0 CAPTURE and 4'h5 during group-1 CAPTURE -> results (A, grp 0, last 0) then (5, grp 1, last 1); first res_valid 11 cycles after accept.
- Backpressure: hold res_ready=0 for 5 cycles in group 0 -> res_* stable, w_rd=0, no group-1 RUN until handshake.
- Reset mid-RUN: rst at k=3 -> next cycle IDLE, res_valid=0, w_rd=0, act_ready=1; a new job then runs from group 0.
- Busy: act_valid held high during a job -> act_ready=0 until res_last handshake; the second vector is accepted in the IDLE cycle after it.
- FCL_SEQ_DOUBLE_BUF_EN with res_ready=0 -> both groups captured, state OUT; the two pops return results in order, then IDLE.
